// File: rtl/mem_port_arbiter_if.sv
// Core-side request/ack bundle plus the single data-memory port shared by fetch and load/store.
// No buffering; requesters hold req until their one-cycle ack.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic              dm_err;
    logic [DATA_W-1:0] dm_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_err, dm_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write, busy
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_err, dm_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; ARB_ROUND_ROBIN_EN selects round-robin ties, else DM wins.
// Latency MEM_LAT+1 to ack (1 if misaligned); requesters stall by holding req until ack.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_own_dm;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_any;
    logic              w_grant_dm;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_misalign;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_if_ack;
    logic              w_dm_ack;
    logic              w_dm_err;

    assign w_any = bus.if_req || bus.dm_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_dm;
    // On a tie, favour whichever port was not granted last.
    assign w_grant_dm = bus.dm_req && (!bus.if_req || !r_last_dm);
`else
    assign w_grant_dm = bus.dm_req;
`endif

    assign w_req_addr = w_grant_dm ? bus.dm_addr : bus.if_addr;
    assign w_misalign = (w_req_addr[1:0] != 2'b00);

    always_comb begin
        w_next      = r_state;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_if_ack    = 1'b0;
        w_dm_ack    = 1'b0;
        w_dm_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_next = w_misalign ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                w_mem_read  = !r_we;
                w_mem_write = r_we;
                if (r_cnt == 4'd0) w_next = S_RESP;
            end
            S_RESP: begin
                w_if_ack = !r_own_dm;
                w_dm_ack = r_own_dm;
                w_dm_err = r_own_dm && r_err;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_own_dm   <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_dm  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_own_dm <= w_grant_dm;
                        r_addr   <= w_req_addr;
                        r_wdata  <= w_grant_dm ? bus.dm_wdata : '0;
                        r_we     <= w_grant_dm && bus.dm_we;
                        r_err    <= w_misalign;
                        r_cnt    <= 4'(MEM_LAT - 1);
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_dm <= w_grant_dm;
`endif
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        // Last strobe cycle: memory data is valid now.
                        if (!r_we && r_own_dm)  r_dm_rdata <= bus.mem_rdata;
                        if (!r_we && !r_own_dm) r_if_rdata <= bus.mem_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_ack    = w_if_ack;
    assign bus.dm_ack    = w_dm_ack;
    assign bus.dm_err    = w_dm_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=2 instance for the main scenarios, MEM_LAT=15 for the latency limit.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        own_dm;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

    mem_port_arbiter #(.MEM_LAT(2), .ADDR_W(32), .DATA_W(32)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );
    mem_port_arbiter #(.MEM_LAT(15), .ADDR_W(32), .DATA_W(32)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    // Memory model: word at byte address A holds bytes A, A+1, A+2, A+3.
    function automatic logic [31:0] pat(input logic [31:0] ad);
        logic [7:0] x;
        x = ad[7:0];
        return {x, x + 8'd1, x + 8'd2, x + 8'd3};
    endfunction

    assign a.mem_rdata = pat(a.mem_addr);
    assign b.mem_rdata = pat(b.mem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (a.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", a.busy); end
        n_cmp++; if ({a.mem_read, a.mem_write, a.if_ack, a.dm_ack, a.dm_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_strobes_acks: got %b want 00000", {a.mem_read, a.mem_write, a.if_ack, a.dm_ack, a.dm_err});
        end
        n_cmp++; if ({a.mem_addr, a.mem_wdata, a.if_rdata, a.dm_rdata} !== 128'h0) begin
            n_bad++; $display("FAIL reset_data: addr %h wdata %h if_rdata %h dm_rdata %h want all 0", a.mem_addr, a.mem_wdata, a.if_rdata, a.dm_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_load();
        exp_t e;
        int   rd_cnt = 0;
        int   ack_cyc = -1;
        logic addr_ok = 1'b1;
        e.own_dm = 1'b1; e.err = 1'b0; e.rdata = 32'h10111213;
        sb_q.push_back(e);
        a.dm_we = 1'b0; a.dm_addr = 32'h10; a.dm_req = 1'b1;
        for (int c = 1; c <= 10 && ack_cyc < 0; c++) begin
            step();
            if (a.mem_read) begin rd_cnt++; if (a.mem_addr !== 32'h10) addr_ok = 1'b0; end
            if (a.dm_ack) begin
                ack_cyc = c;
                a.dm_req = 1'b0;
                if (sb_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL load_sb: unexpected ack"); end
                else begin
                    e = sb_q.pop_front();
                    n_cmp++; if (a.dm_rdata !== e.rdata) begin n_bad++; $display("FAIL load_rdata: got %h want %h", a.dm_rdata, e.rdata); end
                    n_cmp++; if (a.dm_err !== e.err) begin n_bad++; $display("FAIL load_err: got %b want %b", a.dm_err, e.err); end
                end
            end
        end
        a.dm_req = 1'b0;
        n_cmp++; if (ack_cyc != 3) begin n_bad++; $display("FAIL load_ack_cycle: got %0d want 3", ack_cyc); end
        n_cmp++; if (rd_cnt != 2) begin n_bad++; $display("FAIL load_read_cycles: got %0d want 2", rd_cnt); end
        n_cmp++; if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL load_addr: mem_addr not 0x10 during strobe"); end
        step();
        n_cmp++; if ({a.busy, a.dm_ack} !== 2'b00) begin n_bad++; $display("FAIL load_idle: busy,ack got %b want 00", {a.busy, a.dm_ack}); end
    endtask

    task automatic test_store();
        exp_t e;
        int   wr_cnt = 0;
        int   rd_cnt = 0;
        int   ack_cyc = -1;
        logic vals_ok = 1'b1;
        e.own_dm = 1'b1; e.err = 1'b0; e.rdata = 32'h10111213;
        sb_q.push_back(e);
        a.dm_we = 1'b1; a.dm_addr = 32'h20; a.dm_wdata = 32'hDEADBEEF; a.dm_req = 1'b1;
        for (int c = 1; c <= 10 && ack_cyc < 0; c++) begin
            step();
            if (a.mem_read) rd_cnt++;
            if (a.mem_write) begin
                wr_cnt++;
                if (a.mem_addr !== 32'h20 || a.mem_wdata !== 32'hDEADBEEF) vals_ok = 1'b0;
            end
            if (a.dm_ack) begin
                ack_cyc = c;
                a.dm_req = 1'b0;
                if (sb_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL store_sb: unexpected ack"); end
                else begin
                    e = sb_q.pop_front();
                    n_cmp++; if (a.dm_rdata !== e.rdata) begin n_bad++; $display("FAIL store_rdata_kept: got %h want %h", a.dm_rdata, e.rdata); end
                end
            end
        end
        a.dm_req = 1'b0; a.dm_we = 1'b0;
        n_cmp++; if (ack_cyc != 3) begin n_bad++; $display("FAIL store_ack_cycle: got %0d want 3", ack_cyc); end
        n_cmp++; if (wr_cnt != 2) begin n_bad++; $display("FAIL store_write_cycles: got %0d want 2", wr_cnt); end
        n_cmp++; if (rd_cnt != 0) begin n_bad++; $display("FAIL store_no_read: got %0d read cycles want 0", rd_cnt); end
        n_cmp++; if (vals_ok !== 1'b1) begin n_bad++; $display("FAIL store_values: addr/wdata wrong during strobe"); end
        step();
    endtask

    task automatic test_misaligned();
        int   ack_cyc = -1;
        int   strobes = 0;
        logic err_seen = 1'b0;
        a.dm_we = 1'b0; a.dm_addr = 32'h13; a.dm_req = 1'b1;
        for (int c = 1; c <= 6 && ack_cyc < 0; c++) begin
            step();
            if (a.mem_read || a.mem_write) strobes++;
            if (a.dm_ack) begin ack_cyc = c; err_seen = a.dm_err; a.dm_req = 1'b0; end
        end
        a.dm_req = 1'b0;
        n_cmp++; if (ack_cyc != 1) begin n_bad++; $display("FAIL mis_dm_ack_cycle: got %0d want 1", ack_cyc); end
        n_cmp++; if (err_seen !== 1'b1) begin n_bad++; $display("FAIL mis_dm_err: got %b want 1", err_seen); end
        n_cmp++; if (a.dm_rdata !== 32'h10111213) begin n_bad++; $display("FAIL mis_dm_rdata: got %h want 10111213", a.dm_rdata); end
        step();
        ack_cyc = -1;
        a.if_addr = 32'h2; a.if_req = 1'b1;
        for (int c = 1; c <= 6 && ack_cyc < 0; c++) begin
            step();
            if (a.mem_read || a.mem_write) strobes++;
            if (a.dm_err) err_seen = 1'b0;
            if (a.if_ack) begin ack_cyc = c; a.if_req = 1'b0; end
        end
        a.if_req = 1'b0;
        n_cmp++; if (ack_cyc != 1) begin n_bad++; $display("FAIL mis_if_ack_cycle: got %0d want 1", ack_cyc); end
        n_cmp++; if (a.if_rdata !== 32'h0) begin n_bad++; $display("FAIL mis_if_rdata: got %h want 0", a.if_rdata); end
        n_cmp++; if (strobes != 0) begin n_bad++; $display("FAIL mis_strobes: got %0d want 0", strobes); end
        step();
    endtask

    task automatic test_tie_break();
        exp_t e;
        int   acks = 0;
        int   if_acks = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            e.own_dm = (i % 2 == 0);
`else
            e.own_dm = 1'b1;
`endif
            e.err   = 1'b0;
            e.rdata = e.own_dm ? 32'h44454647 : 32'h40414243;
            sb_q.push_back(e);
        end
        a.dm_we = 1'b0; a.dm_addr = 32'h44; a.if_addr = 32'h40;
        a.dm_req = 1'b1; a.if_req = 1'b1;
        for (int c = 1; c <= 40 && acks < 4; c++) begin
            step();
            n_cmp++; if (a.mem_read && a.mem_write) begin n_bad++; $display("FAIL tie_strobe_excl: both strobes high"); end
            if (a.if_ack || a.dm_ack) begin
                acks++;
                if (a.if_ack) if_acks++;
                if (acks == 4) begin a.dm_req = 1'b0; a.if_req = 1'b0; end
                if (sb_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL tie_sb: unexpected ack"); end
                else begin
                    e = sb_q.pop_front();
                    n_cmp++; if (a.dm_ack !== e.own_dm || a.if_ack !== !e.own_dm) begin
                        n_bad++; $display("FAIL tie_owner[%0d]: dm_ack %b if_ack %b want dm=%b", acks, a.dm_ack, a.if_ack, e.own_dm);
                    end
                    n_cmp++; if ((e.own_dm ? a.dm_rdata : a.if_rdata) !== e.rdata) begin
                        n_bad++; $display("FAIL tie_rdata[%0d]: got %h want %h", acks, e.own_dm ? a.dm_rdata : a.if_rdata, e.rdata);
                    end
                end
            end
        end
        a.dm_req = 1'b0; a.if_req = 1'b0;
        n_cmp++; if (acks != 4) begin n_bad++; $display("FAIL tie_ack_count: got %0d want 4", acks); end
`ifdef ARB_ROUND_ROBIN_EN
        n_cmp++; if (if_acks != 2) begin n_bad++; $display("FAIL tie_if_acks: got %0d want 2", if_acks); end
`else
        n_cmp++; if (if_acks != 0) begin n_bad++; $display("FAIL tie_if_acks: got %0d want 0", if_acks); end
`endif
        step();
        n_cmp++; if (a.busy !== 1'b0) begin n_bad++; $display("FAIL tie_idle: busy %b want 0", a.busy); end
        sb_q.delete();
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        int   ack_cyc = -1;
        int   stray = 0;
        a.dm_we = 1'b0; a.dm_addr = 32'h30; a.dm_req = 1'b1;
        step();
        n_cmp++; if (a.mem_read !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre: mem_read %b want 1", a.mem_read); end
        rst = 1'b1;
        step();
        n_cmp++; if ({a.mem_read, a.mem_write, a.busy, a.dm_ack, a.if_ack} !== 5'b0) begin
            n_bad++; $display("FAIL rst_mid_ctrl: got %b want 00000", {a.mem_read, a.mem_write, a.busy, a.dm_ack, a.if_ack});
        end
        n_cmp++; if ({a.if_rdata, a.dm_rdata, a.mem_addr} !== 96'h0) begin
            n_bad++; $display("FAIL rst_mid_data: if %h dm %h addr %h want 0", a.if_rdata, a.dm_rdata, a.mem_addr);
        end
        rst = 1'b0; a.dm_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (a.dm_ack || a.if_ack) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL rst_mid_no_ack: got %0d acks want 0", stray); end
        e.own_dm = 1'b0; e.err = 1'b0; e.rdata = 32'h00010203;
        sb_q.push_back(e);
        a.if_addr = 32'h0; a.if_req = 1'b1;
        for (int c = 1; c <= 10 && ack_cyc < 0; c++) begin
            step();
            if (a.if_ack) begin
                ack_cyc = c;
                a.if_req = 1'b0;
                if (sb_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL rst_fetch_sb: unexpected ack"); end
                else begin
                    e = sb_q.pop_front();
                    n_cmp++; if (a.if_rdata !== e.rdata) begin n_bad++; $display("FAIL rst_fetch_rdata: got %h want %h", a.if_rdata, e.rdata); end
                end
            end
        end
        a.if_req = 1'b0;
        n_cmp++; if (ack_cyc != 3) begin n_bad++; $display("FAIL rst_fetch_ack_cycle: got %0d want 3", ack_cyc); end
        step();
    endtask

    task automatic test_max_latency();
        exp_t e;
        int   rd_cnt = 0;
        int   ack_cyc = -1;
        e.own_dm = 1'b0; e.err = 1'b0; e.rdata = 32'h04050607;
        sb_q.push_back(e);
        b.if_addr = 32'h4; b.if_req = 1'b1;
        for (int c = 1; c <= 30 && ack_cyc < 0; c++) begin
            step();
            if (b.mem_read) rd_cnt++;
            if (b.if_ack) begin
                ack_cyc = c;
                b.if_req = 1'b0;
                if (sb_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL maxlat_sb: unexpected ack"); end
                else begin
                    e = sb_q.pop_front();
                    n_cmp++; if (b.if_rdata !== e.rdata) begin n_bad++; $display("FAIL maxlat_rdata: got %h want %h", b.if_rdata, e.rdata); end
                end
            end
        end
        b.if_req = 1'b0;
        n_cmp++; if (rd_cnt != 15) begin n_bad++; $display("FAIL maxlat_read_cycles: got %0d want 15", rd_cnt); end
        n_cmp++; if (ack_cyc != 16) begin n_bad++; $display("FAIL maxlat_ack_cycle: got %0d want 16", ack_cyc); end
        step();
        n_cmp++; if (b.busy !== 1'b0) begin n_bad++; $display("FAIL maxlat_idle: busy %b want 0", b.busy); end
    endtask

    initial begin
        a.if_req = 1'b0; a.if_addr = '0; a.dm_req = 1'b0; a.dm_we = 1'b0; a.dm_addr = '0; a.dm_wdata = '0;
        b.if_req = 1'b0; b.if_addr = '0; b.dm_req = 1'b0; b.dm_we = 1'b0; b.dm_addr = '0; b.dm_wdata = '0;
        test_reset();
        test_single_load();
        test_store();
        test_misaligned();
        test_tie_break();
        test_reset_mid_access();
        test_max_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Two-requester controller that shares the single word-wide data memory port between the instruction-fetch path and the load/store path of the multicycle MIPS core.
- Arbitrates, latches the winning request, sequences the memory read or write strobes for a fixed latency, and returns read data with a one-cycle acknowledge.
- Sits between the core's control unit and the DataMemory instance.

## Interface
Parameters:
- `MEM_LAT`, 2: cycles the memory strobe is held per access; legal range 1..15.
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data word width.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch read request; held with `if_addr` until `if_ack`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_ack`  out  1  one-cycle completion pulse for fetch.
- `if_rdata`  out  DATA_W  fetch read data; valid in the `if_ack` cycle and held after it.
- `dm_req`  in  1  load/store request; held with its fields until `dm_ack`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  ADDR_W  load/store byte address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_ack`  out  1  one-cycle completion pulse for load/store.
- `dm_err`  out  1  pulses together with `dm_ack` when the access was misaligned.
- `dm_rdata`  out  DATA_W  load data; valid in the `dm_ack` cycle and held after it.
- `mem_addr`  out  ADDR_W  memory address, driven from the latched request.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- State machine has three states: IDLE, ACCESS and RESP.
- **IDLE:** if any `*_req` is high, select a winner and latch its address, write data and write-enable into internal registers. Also record the owner (IF or DM). Set cnt = MEM_LAT-1 and go to ACCESS.
- **Misaligned access:** a winning request with addr[1:0] != 0 skips ACCESS and goes straight to RESP with the error flag set. No memory strobe is issued.
  - `dm_err` pulses with `dm_ack` for a misaligned load/store.
  - A misaligned fetch acks with `if_rdata` unchanged; fetch has no error output.
- **ACCESS:** `mem_read` = !we, `mem_write` = we, and `mem_addr`/`mem_wdata` come from the latches. All three are stable for exactly MEM_LAT cycles.
  - cnt decrements each cycle.
  - At cnt == 0: for a read, capture `mem_rdata` into the owner's rdata register; then go to RESP.
- **RESP:** pulse the owner's ack for one cycle, then return to IDLE. The losing requester is never acked.
- **Writes:** `dm_rdata` keeps its previous value.
- **Strobes:** `mem_read` and `mem_write` are never high together, and both are 0 outside ACCESS.
- **Tie-break:** applies when both requests are high in IDLE; see Configuration. A single requester is always granted.
- **Request dropped before ack:** this is a protocol violation. The latched transaction still completes and acks normally.
- **Re-request:** a requester may hold its req high in the cycle after its ack to issue the next access. That request is seen in IDLE.
- **Reset:** applies in any state, including mid-ACCESS.
  - Next state is IDLE and cnt = 0.
  - All acks, `dm_err`, `mem_read`, `mem_write` and `busy` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` = 0.
  - The in-flight access is dropped and never acked.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from req to ack.
- Request seen in IDLE at cycle 0:
  - strobes high in cycles 1..MEM_LAT;
  - ack in cycle MEM_LAT+1;
  - IDLE again in cycle MEM_LAT+2.
- Throughput is one access per MEM_LAT+2 cycles.
- Misaligned request: ack and err in cycle 1, with no strobe.
- Read data is sampled from `mem_rdata` on the last ACCESS cycle.

## Configuration
- Macro: `ARB_ROUND_ROBIN_EN`.
- **Defined:** a one-bit last-grant register decides ties in favour of the port not granted most recently. It updates on every grant and resets to IF, so the first tie goes to DM.
- **Undefined:** fixed priority; DM always wins ties. A continuously requesting DM port starves IF. The last-grant register is not built.

## Test plan
- **Single load:** MEM_LAT=2; `dm_req`=1, `dm_we`=0, `dm_addr`=0x10, memory returns 0x10111213 → `mem_read` high in cycles 1–2, `dm_ack` and `dm_rdata`=0x10111213 in cycle 3, `busy` low in cycle 4.
- **Store:** `dm_we`=1, `dm_addr`=0x20, `dm_wdata`=0xDEADBEEF → `mem_write` high for 2 cycles with those values, `mem_read` stays 0, `dm_ack` in cycle 3, `dm_rdata` unchanged.
- **Tie-break:** both requests held high for 4 accesses → round-robin build grants DM, IF, DM, IF; fixed-priority build grants DM ×4 with `if_ack` never asserted.
- **Misaligned:** `dm_addr`=0x13 → `dm_ack` and `dm_err` in cycle 1, no strobe.
- **Reset mid-access:** `rst` asserted in cycle 1 of ACCESS → strobes, `busy` and rdata are 0 in the next cycle, no ack; a fresh `if_req` to 0x0 afterwards completes normally.
- **Max latency:** MEM_LAT=15, fetch at 0x4 → `mem_read` high for exactly 15 cycles, `if_ack` in cycle 16.
